// File: rtl/lap_mem_ctrl.sv
// lap_mem_ctrl: lap-time store for a stopwatch.
//   clk, nrst    clock, asynchronous active-low reset
//   clear        synchronous wipe of all entries, pointers and flags
//   lap_req      capture count into the next entry (ignored while busy)
//   count        live stopwatch value
//   scroll_req   step the displayed entry, oldest..newest, wrapping
//   lap_data     registered displayed entry (0 when empty)
//   lap_index    age of displayed entry, 0 = oldest
//   lap_count    number of valid entries, 0..DEPTH
//   empty/full   lap_count == 0 / lap_count == DEPTH
//   overflow     sticky: a capture overwrote the oldest entry
//   busy         high during the WRITE cycle
module lap_mem_ctrl #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       clear,
  input  logic                       lap_req,
  input  logic [WIDTH-1:0]           count,
  input  logic                       scroll_req,
  output logic [WIDTH-1:0]           lap_data,
  output logic [$clog2(DEPTH)-1:0]   lap_index,
  output logic [$clog2(DEPTH):0]     lap_count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    oldest;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    last_idx;
  logic [AW-1:0]    next_idx;
  logic [AW-1:0]    rd_addr;

  // DEPTH is a power of two, so AW-bit wraparound gives the modulo arithmetic.
  always_comb begin
    last_idx = lap_count - CW'(1);
    next_idx = ({1'b0, lap_index} == last_idx) ? '0 : lap_index + AW'(1);
    rd_addr  = oldest + next_idx;
  end

  assign busy  = (state == WRITE);
  assign empty = (lap_count == '0);
  assign full  = (lap_count == CW'(DEPTH));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      hold      <= '0;
      wr_ptr    <= '0;
      oldest    <= '0;
      lap_index <= '0;
      lap_count <= '0;
      lap_data  <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      oldest    <= '0;
      lap_index <= '0;
      lap_count <= '0;
      lap_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lap_req) begin
            hold  <= count;
            state <= WRITE;
          end else if (scroll_req && !empty) begin
            lap_index <= next_idx;
            lap_data  <= mem[rd_addr];
          end
        end
        WRITE: begin
          // The newest entry is the hold register itself, so the display
          // snaps to it without a memory read.
          wr_ptr   <= wr_ptr + AW'(1);
          lap_data <= hold;
          state    <= IDLE;
          if (full) begin
            oldest    <= oldest + AW'(1);
            overflow  <= 1'b1;
            lap_index <= AW'(DEPTH - 1);
          end else begin
            lap_count <= lap_count + CW'(1);
            lap_index <= lap_count[AW-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; a clear during WRITE suppresses the store.
  always_ff @(posedge clk) begin
    if (state == WRITE && !clear)
      mem[wr_ptr] <= hold;
  end

endmodule

// File: tb/tb_lap_mem_ctrl.sv
module tb_lap_mem_ctrl;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              clear = 1'b0;
  logic              lap_req = 1'b0;
  logic [WIDTH-1:0]  count = '0;
  logic              scroll_req = 1'b0;
  logic [WIDTH-1:0]  lap_data;
  logic [1:0]        lap_index;
  logic [2:0]        lap_count;
  logic              empty, full, overflow, busy;

  lap_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .clear(clear), .lap_req(lap_req), .count(count),
    .scroll_req(scroll_req), .lap_data(lap_data), .lap_index(lap_index),
    .lap_count(lap_count), .empty(empty), .full(full), .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               idx;
    int               cnt;
    bit               ovf;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] mq[$];
  int               midx;
  bit               movf;
  int               n_tests = 0;
  int               n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    midx = 0;
    movf = 1'b0;
  endfunction

  function automatic void model_capture(input logic [WIDTH-1:0] v);
    if (mq.size() == DEPTH) begin
      void'(mq.pop_front());
      movf = 1'b1;
    end
    mq.push_back(v);
    midx = mq.size() - 1;
  endfunction

  function automatic void model_scroll();
    if (mq.size() > 0)
      midx = (midx == mq.size() - 1) ? 0 : midx + 1;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.data = (mq.size() > 0) ? mq[midx] : '0;
    e.idx  = midx;
    e.cnt  = mq.size();
    e.ovf  = movf;
    sb.push_back(e);
  endfunction

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_data"},  32'(lap_data),  32'(e.data));
    check({tag, "_index"}, 32'(lap_index), 32'(e.idx));
    check({tag, "_count"}, 32'(lap_count), 32'(e.cnt));
    check({tag, "_ovf"},   32'(overflow),  32'(e.ovf));
    check({tag, "_empty"}, 32'(empty),     32'(e.cnt == 0));
    check({tag, "_full"},  32'(full),      32'(e.cnt == DEPTH));
  endtask

  // Capture; optional scroll in the request cycle and lap_req held into WRITE.
  task automatic do_lap(input string tag, input logic [WIDTH-1:0] v,
                        input bit with_scroll, input bit hold_req);
    @(negedge clk);
    lap_req = 1'b1; count = v; scroll_req = with_scroll;
    @(negedge clk);
    lap_req = hold_req; count = ~v; scroll_req = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    model_capture(v);
    push_exp();
    @(negedge clk);
    lap_req = 1'b0;
    check({tag, "_idle"}, 32'(busy), 32'd0);
    pop_and_check(tag);
  endtask

  task automatic do_scroll(input string tag);
    @(negedge clk);
    scroll_req = 1'b1;
    @(negedge clk);
    scroll_req = 1'b0;
    model_scroll();
    push_exp();
    pop_and_check(tag);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(lap_data),  32'd0);
    check({tag, "_index"}, 32'(lap_index), 32'd0);
    check({tag, "_count"}, 32'(lap_count), 32'd0);
    check({tag, "_empty"}, 32'(empty),     32'd1);
    check({tag, "_full"},  32'(full),      32'd0);
    check({tag, "_ovf"},   32'(overflow),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // Single capture.
    do_lap("first", 12'h005, 1'b0, 1'b0);

    // Fill past DEPTH, then walk the display around from the newest.
    do_clear();
    for (int unsigned i = 1; i <= 5; i++)
      do_lap("fill", WIDTH'(i), 1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++)
      do_scroll("wrap");

    // Clear during WRITE aborts the store and wipes the flags.
    @(negedge clk);
    lap_req = 1'b1; count = 12'h0AB;
    @(negedge clk);
    lap_req = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    push_exp();
    pop_and_check("clr_wr");
    do_scroll("scroll_empty");

    // Back-to-back lap_req: second lands in WRITE and is ignored.
    do_lap("b2b", 12'h123, 1'b0, 1'b1);
    @(negedge clk);
    push_exp();
    pop_and_check("b2b_after");

    // Capture wins over a simultaneous scroll.
    do_clear();
    do_lap("two_a", 12'h010, 1'b0, 1'b0);
    do_lap("two_b", 12'h020, 1'b0, 1'b0);
    do_scroll("two_scr");
    do_lap("lap_scr", 12'h030, 1'b1, 1'b0);

    // Random mix of captures and scrolls against the model.
    for (int unsigned i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0)
        do_lap("rnd_lap", WIDTH'($urandom), 1'b0, 1'b0);
      else
        do_scroll("rnd_scr");
    end

    // Asynchronous reset between edges with three entries.
    do_clear();
    do_lap("r3a", 12'hFFF, 1'b0, 1'b0);
    do_lap("r3b", 12'h800, 1'b0, 1'b0);
    do_lap("r3c", 12'h001, 1'b0, 1'b0);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #2 nrst = 1'b1;

    // First request after reset release is honoured.
    do_lap("post_rst", 12'h5A5, 1'b0, 1'b0);
    do_scroll("post_rst_scr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lap_mem_ctrl.md
LAP_MEM_CTRL -- requirements
Module: lap_mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 12, the lap value width in bits (matches the stopwatch count).
REQ-002 SHALL have parameter DEPTH, default 4, the number of lap entries; it is a power of two and at least 2.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 nrst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 clear  input  1  synchronous clear of all lap storage and flags.
REQ-006 lap_req  input  1  single-cycle pulse requesting capture of count.
REQ-007 count  input  WIDTH  live stopwatch value to capture.
REQ-008 scroll_req  input  1  single-cycle pulse advancing the displayed entry.
REQ-009 lap_data  output  WIDTH  registered value of the displayed entry.
REQ-010 lap_index  output  log2(DEPTH)  age position of the displayed entry (0 = oldest).
REQ-011 lap_count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-012 empty / full  output  1 each  lap_count==0 / lap_count==DEPTH.
REQ-013 overflow  output  1  sticky flag: a capture overwrote the oldest entry.
REQ-014 busy  output  1  high while in state WRITE.

Function
REQ-015 SHALL implement states IDLE and WRITE; reset and clear state = IDLE.
REQ-016 IDLE + lap_req=1: SHALL latch count into a hold register and go to WRITE the next cycle.
REQ-017 WRITE: SHALL write the hold register to mem[wr_ptr], advance wr_ptr modulo DEPTH, and return to IDLE unconditionally.
REQ-018 lap_req while busy=1 SHALL be ignored (no capture, no queueing).
REQ-019 Capture with lap_count<DEPTH: lap_count SHALL increment by 1.
REQ-020 Capture with full=1: lap_count SHALL stay DEPTH, the oldest pointer SHALL advance by 1, and overflow SHALL set and remain set until clear or reset.
REQ-021 After a capture, the display SHALL snap to the newest entry: lap_index=lap_count-1, with lap_data valid 2 cycles after the lap_req cycle.
REQ-022 scroll_req in IDLE with lap_count>0 SHALL advance lap_index by 1, wrapping from lap_count-1 to 0; lap_data SHALL update on the next edge.
REQ-023 scroll_req with empty=1 SHALL be ignored.
REQ-024 scroll_req in the same cycle as lap_req, or while busy=1, SHALL be dropped; capture has priority.
REQ-025 lap_data SHALL be 0 whenever empty=1.
REQ-026 clear SHALL take priority over lap_req and scroll_req in the same cycle and SHALL abort a WRITE in progress (entry not stored).
REQ-027 clear SHALL zero lap_count, wr_ptr, the oldest pointer, lap_index, lap_data and overflow, and SHALL return the FSM to IDLE; memory contents need not be zeroed.
REQ-028 Pointer and index arithmetic SHALL be modulo DEPTH; the displayed address is (oldest + lap_index) mod DEPTH.
REQ-029 count SHALL be captured unmodified (no saturation or conversion).

Reset
REQ-030 nrst=0 SHALL immediately force state IDLE, lap_data=0, lap_index=0, lap_count=0, empty=1, full=0, overflow=0, busy=0, independent of clk.
REQ-031 Reset asserted mid-WRITE SHALL discard the pending capture.
REQ-032 After nrst rises, the first lap_req SHALL be honoured on the first clock edge.

Verification
REQ-033 Reset, then lap_req with count=12'h005 -> busy=1 for 1 cycle, then lap_count=1, lap_index=0, lap_data=12'h005.
REQ-034 Capture 12'h001..12'h005 (DEPTH=4) -> full=1, overflow=1, lap_count=4; four scroll_req from the newest entry -> lap_data sequence 002, 003, 004, 005 (wraps through oldest=002).
REQ-035 lap_req pulses on 2 consecutive cycles -> only the first is captured; lap_count increments by 1.
REQ-036 lap_req and scroll_req in the same cycle with 2 entries -> capture occurs, lap_index=2 (newest), scroll dropped.
REQ-037 clear in the WRITE cycle -> lap_count=0, empty=1, overflow=0, lap_data=0; a subsequent scroll_req has no effect.
REQ-038 nrst pulsed low between clock edges with lap_count=3 -> all outputs at reset values before the next edge.
